addsub_seq_16: RTL and testbench
================================

# addsub_seq_16

Multi-cycle add/subtract sequencer that time-shares one 4-bit ripple adder to process NIBBLES×4-bit operands, one nibble per clock, LSB nibble first, with carry chained through a register. It sits between a requesting datapath (start/operands in, result/done out) and the team's existing 4-bit adder, trading latency for area. Subtraction is two's-complement: B is inverted and the initial carry is set to 1.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit digits per operand; operand width W = 4×NIBBLES (NIBBLES ≥ 1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = A+B, 1 = A−B; sampled with start
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- result  output  W  sum/difference; held until next accepted start
- cout  output  1  carry out of MSB nibble (for sub: 1 = no borrow)
- ovf  output  1  signed overflow of the W-bit operation

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge → latch a, b_eff = sub ? ~b : b, carry = sub, idx = 0, clear result/cout/ovf; go RUN. start=0 → stay IDLE.
- RUN: each edge feeds nibble idx of A and b_eff plus carry into the 4-bit adder; writes the sum into result[4·idx+3:4·idx], carry ← adder carry out, idx ← idx+1. On the edge processing idx = NIBBLES−1: cout ← adder carry out, ovf computed, go DONE.
- ovf = (A[W−1] == b_eff[W−1]) && (result[W−1] != A[W−1]), using the final MSB nibble sum.
- DONE: done=1 for exactly this cycle; next edge → IDLE unconditionally.
- start in RUN or DONE is ignored (not queued); a, b, sub changes after acceptance have no effect.
- idx counter width = max(1, clog2(NIBBLES)); no wrap occurs because RUN exits at NIBBLES−1.
- NIBBLES = 1: RUN lasts one cycle.

## Timing
- Reset: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, idx=0, carry=0. rst has priority over every other input, including mid-RUN/DONE: the operation is aborted, no done pulse.
- start accepted at edge k → busy=1 from cycle after k; nibble i written at edge k+1+i; state DONE and done=1 during the cycle after edge k+NIBBLES; IDLE after edge k+NIBBLES+1.
- Latency start-edge to done-high: NIBBLES+1 cycles (5 for default). Throughput: one operation per NIBBLES+2 cycles (start can be re-accepted at edge k+NIBBLES+2).
- result, cout, ovf are stable and final whenever done=1 and stay held through IDLE.
- Partially written result is visible during RUN; consumers use only done.

## Structure
- Shared package/include addsub_seq_pkg: state encoding localparams (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2), NIBBLE_W=4.
- One sub-module: the existing 4-bit adder `adder` (A, B, C0, O, C1), instantiated once; all sequencing, muxing of the current nibble, and carry/result registers live in addsub_seq_16.
- Unused state encoding 2'd3 → IDLE.

## Test plan
- Add: a=16'h1234, b=16'h4321, sub=0 → result=16'h5555, cout=0, ovf=0, done exactly 5 cycles after start edge, one cycle wide.
- Carry chain: a=16'hFFFF, b=16'h0001, sub=0 → result=16'h0000, cout=1, ovf=0; a=16'h7FFF, b=16'h0001 → result=16'h8000, cout=0, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1 → result=16'hFFFE, cout=0, ovf=0; a=16'h8000, b=16'h0001, sub=1 → result=16'h7FFF, cout=1, ovf=1.
- Busy protocol: second start (a=16'h1111, b=16'h1111) pulsed during RUN → ignored, first result 16'h5555 unaffected, only one done pulse; back-to-back start at earliest legal edge accepted.
- Reset mid-op: rst=1 during second RUN cycle → next cycle busy=0, done=0, result=0, cout=0, ovf=0; no done pulse; fresh start then completes normally.
- Parameter: NIBBLES=1, a=4'h9, b=4'h8, sub=0 → result=4'h1, cout=1, ovf=1, done 2 cycles after start.

Source files
------------

// File: rtl/addsub_seq_pkg.sv
// Purpose: shared constants and state type for the nibble-serial add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_seq_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } state_t;

endpackage

// File: rtl/addsub_seq_16_if.sv
// Purpose: request/response bundle between a requesting datapath and addsub_seq_16.
// Latency: n/a (wires only). Ports: start/sub/a/b requester->sequencer; busy/done/result/cout/ovf back.
// Backpressure: none; requester must wait for busy=0 before a start is honoured.
interface addsub_seq_16_if
   import addsub_seq_pkg::*;
#(
   parameter int NIBBLES = 4
);
   localparam int W = NIBBLE_W * NIBBLES;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, cout, ovf
   );

endinterface

// File: rtl/adder.sv
// Purpose: the existing 4-bit adder. Ports: A, B nibbles, C0 carry in; O sum, C1 carry out.
// Latency: combinational.
// Backpressure: n/a.
module adder (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       C0,
   output logic [3:0] O,
   output logic       C1
);

   assign {C1, O} = {1'b0, A} + {1'b0, B} + {4'b0000, C0};

endmodule

// File: rtl/addsub_seq_16.sv
// Purpose: W-bit add/subtract done one nibble per clock through a single shared 4-bit adder.
// Latency: NIBBLES+1 cycles start-edge to done; one op per NIBBLES+2 cycles. Ports: clk, rst, bus (slave).
// Backpressure: start is only honoured in IDLE; starts while busy are dropped, not queued.
module addsub_seq_16
   import addsub_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input logic            clk,
   input logic            rst,
   addsub_seq_16_if.slave bus
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t               r_state;
   logic [W-1:0]         r_a;
   logic [W-1:0]         r_b_eff;
   logic [W-1:0]         r_result;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_carry;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_cout;
   logic                 r_ovf;

   logic [NIBBLE_W-1:0]  w_a_nib;
   logic [NIBBLE_W-1:0]  w_b_nib;
   logic [NIBBLE_W-1:0]  w_sum;
   logic                 w_c1;
   logic                 w_last;
   logic                 w_ovf;

   // Current digit of each operand, selected by the nibble index.
   assign w_a_nib = r_a[int'(r_idx) * NIBBLE_W +: NIBBLE_W];
   assign w_b_nib = r_b_eff[int'(r_idx) * NIBBLE_W +: NIBBLE_W];
   assign w_last  = (r_idx == LAST_IDX);

   // Signed overflow: operands agree in sign but the final MSB nibble's top bit disagrees.
   assign w_ovf = (r_a[W-1] == r_b_eff[W-1]) && (w_sum[NIBBLE_W-1] != r_a[W-1]);

   adder u_adder (
      .A  (w_a_nib),
      .B  (w_b_nib),
      .C0 (r_carry),
      .O  (w_sum),
      .C1 (w_c1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b_eff  <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  // Subtraction as A + ~B + 1: invert B and seed the carry.
                  r_a      <= bus.a;
                  r_b_eff  <= bus.sub ? ~bus.b : bus.b;
                  r_carry  <= bus.sub;
                  r_idx    <= '0;
                  r_result <= '0;
                  r_cout   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_result[int'(r_idx) * NIBBLE_W +: NIBBLE_W] <= w_sum;
               r_carry <= w_c1;
               if (w_last) begin
                  // Index is left at the last digit so it never wraps.
                  r_cout  <= w_c1;
                  r_ovf   <= w_ovf;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.cout   = r_cout;
   assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_addsub_seq_16.sv
// Purpose: scoreboard bench for addsub_seq_16 at NIBBLES=4 and NIBBLES=1.
// Latency: expects done NIBBLES+1 cycles after the accepting edge.
// Backpressure: issues starts only when the sequencer is idle, plus deliberate starts while busy.
module tb_addsub_seq_16;

   typedef struct {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      int          k;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t q4[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   addsub_seq_16_if #(.NIBBLES(4)) bus4 ();
   addsub_seq_16_if #(.NIBBLES(1)) bus1 ();

   addsub_seq_16 #(.NIBBLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
   addsub_seq_16 #(.NIBBLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitors: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus4.done === 1'b1) begin
         chk("dut4_done_expected", 32'(q4.size() > 0), 32'd1);
         if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("dut4_result",  32'(bus4.result), 32'(e.res));
            chk("dut4_cout",    32'(bus4.cout),   32'(e.cout));
            chk("dut4_ovf",     32'(bus4.ovf),    32'(e.ovf));
            chk("dut4_latency", cyc - e.k + 1,    32'd5);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus1.done === 1'b1) begin
         chk("dut1_done_expected", 32'(q1.size() > 0), 32'd1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("dut1_result",  32'(bus1.result), 32'(e.res[3:0]));
            chk("dut1_cout",    32'(bus1.cout),   32'(e.cout));
            chk("dut1_ovf",     32'(bus1.ovf),    32'(e.ovf));
            chk("dut1_latency", cyc - e.k + 1,    32'd2);
         end
      end
   end

   // Call just after a negedge. Inputs are scrambled after acceptance to show they are latched.
   task automatic go4(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input bit expect_done, input logic [15:0] er, input logic ec,
                      input logic eo, output int k);
      bus4.a = a; bus4.b = b; bus4.sub = sub; bus4.start = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      if (expect_done) q4.push_back('{er, ec, eo, k});
      bus4.start = 1'b0; bus4.a = ~a; bus4.b = ~b; bus4.sub = ~sub;
   endtask

   task automatic go1(input logic [3:0] a, input logic [3:0] b, input logic sub,
                      input logic [3:0] er, input logic ec, input logic eo);
      int k;
      bus1.a = a; bus1.b = b; bus1.sub = sub; bus1.start = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      q1.push_back('{{12'h000, er}, ec, eo, k});
      bus1.start = 1'b0; bus1.a = ~a; bus1.b = ~b;
   endtask

   task automatic wait_done4();
      int n = 0;
      while (bus4.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus4.done !== 1'b1) chk("dut4_done_timeout", 32'(bus4.done), 32'd1);
   endtask

   task automatic wait_done1();
      int n = 0;
      while (bus1.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus1.done !== 1'b1) chk("dut1_done_timeout", 32'(bus1.done), 32'd1);
   endtask

   // Step from a done cycle to the earliest edge that can accept a new start.
   task automatic to_idle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int k;
      bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0;
      bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",   32'(bus4.busy),   32'd0);
      chk("rst_done",   32'(bus4.done),   32'd0);
      chk("rst_result", 32'(bus4.result), 32'd0);
      chk("rst_cout",   32'(bus4.cout),   32'd0);
      chk("rst_ovf",    32'(bus4.ovf),    32'd0);
      chk("rst1_busy",  32'(bus1.busy),   32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Plain add, with an extra start dropped while running.
      go4(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, k);
      @(negedge clk);
      chk("busy_after_accept", 32'(bus4.busy), 32'd1);
      bus4.a = 16'h1111; bus4.b = 16'h1111; bus4.sub = 1'b0; bus4.start = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      wait_done4();
      chk("busy_in_done", 32'(bus4.busy), 32'd1);
      to_idle();
      chk("busy_idle", 32'(bus4.busy), 32'd0);

      // Back-to-back at the earliest legal edge.
      go4(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, k);
      wait_done4();
      to_idle();
      go4(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, k);
      wait_done4();
      to_idle();
      go4(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, k);
      wait_done4();
      to_idle();
      go4(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, k);
      wait_done4();

      // Results stay held once back in IDLE.
      @(posedge clk);
      repeat (2) @(negedge clk);
      chk("hold_result", 32'(bus4.result), 32'h7FFF);
      chk("hold_cout",   32'(bus4.cout),   32'd1);
      chk("hold_ovf",    32'(bus4.ovf),    32'd1);
      chk("hold_busy",   32'(bus4.busy),   32'd0);

      // Reset during the second RUN cycle aborts the operation without a done pulse.
      go4(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, k);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy",   32'(bus4.busy),   32'd0);
      chk("abort_done",   32'(bus4.done),   32'd0);
      chk("abort_result", 32'(bus4.result), 32'd0);
      chk("abort_cout",   32'(bus4.cout),   32'd0);
      chk("abort_ovf",    32'(bus4.ovf),    32'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      go4(16'hABCD, 16'h1111, 1'b0, 1'b1, 16'hBCDE, 1'b0, 1'b0, k);
      wait_done4();
      to_idle();
      go4(16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, k);
      wait_done4();

      // Single-nibble instance.
      @(negedge clk);
      go1(4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1);
      wait_done1();
      to_idle();
      go1(4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);
      wait_done1();

      repeat (5) @(negedge clk);
      chk("q4_drained", 32'(q4.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
